alu_nzcv_seq: RTL and testbench

Sequential, parametrised successor to the combinational NZCV ALU. It adds an operand/result handshake, a persistent NZCV flag register, carry-chained ADC/SBC, compare, and an iterative shift-add multiplier. It sits between a register-file/operand source and a result consumer. It is the arithmetic core for the upcoming multi-cycle datapath and the board-level calculator demo.

---
 rtl/alu_nzcv_seq_if.sv | 25 ++
 rtl/alu_nzcv_seq.sv | 151 +++++++++++++++
 tb/tb_alu_nzcv_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_nzcv_seq_if.sv
// Operand/result handshake bundle for alu_nzcv_seq.
// master drives operands and consumes results; slave is the ALU.
interface alu_nzcv_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             set_flags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       nzcv;
  logic             busy;

  modport master (
    output in_valid, a, b, op, set_flags, out_ready,
    input  in_ready, out_valid, result, nzcv, busy
  );

  modport slave (
    input  in_valid, a, b, op, set_flags, out_ready,
    output in_ready, out_valid, result, nzcv, busy
  );
endinterface

// File: rtl/alu_nzcv_seq.sv
// Sequential NZCV ALU: handshaked operands, persistent flag register, ADC/SBC/CMP,
// and an iterative shift-add multiplier enabled by ALU_NZCV_SEQ_MUL_EN.
module alu_nzcv_seq #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  alu_nzcv_seq_if.slave bus
);
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
                         OP_ADC = 3'b100, OP_SBC = 3'b101, OP_MUL = 3'b110, OP_CMP = 3'b111;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [3:0]       nzcv;
  } rsp_t;

  logic [WIDTH-1:0] result_q;
  logic [3:0]       nzcv_q;
  logic             out_valid_q;
  logic             idle, accept, wr_alu, wr_mul, mul_sf;
  rsp_t             alu_rsp, mul_rsp;

  assign bus.in_ready  = idle && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.nzcv      = nzcv_q;

  // Single-cycle path works straight off the bus, so operands and C are
  // captured by the same edge that accepts them.
  logic [WIDTH-1:0] add_b, alu_res;
  logic [WIDTH:0]   sum;
  logic             add_cin, is_arith, cf, vf;

  always_comb begin
    add_b    = bus.b;
    add_cin  = 1'b0;
    is_arith = 1'b1;
    case (bus.op)
      OP_ADD:         add_cin = 1'b0;
      OP_SUB, OP_CMP: begin add_b = ~bus.b; add_cin = 1'b1; end
      OP_ADC:         add_cin = nzcv_q[1];
      OP_SBC:         begin add_b = ~bus.b; add_cin = nzcv_q[1]; end
      default:        is_arith = 1'b0;
    endcase
    sum     = {1'b0, bus.a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    alu_res = '0;
    cf      = 1'b0;
    vf      = 1'b0;
    if (is_arith) begin
      alu_res = sum[WIDTH-1:0];
      cf      = sum[WIDTH];
      vf      = (bus.a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    end else if (bus.op == OP_AND) begin
      alu_res = bus.a & bus.b;
    end else if (bus.op == OP_OR) begin
      alu_res = bus.a | bus.b;
    end
    alu_rsp.res  = alu_res;
    alu_rsp.nzcv = {alu_res[WIDTH-1], alu_res == '0, cf, vf};
  end

`ifdef ALU_NZCV_SEQ_MUL_EN
  localparam int STAGES = WIDTH - 1;

  typedef enum logic {IDLE, MUL} state_t;
  state_t state_q, state_d;

  logic [STAGES:0]    vld_pipe;
  logic [2*WIDTH-1:0] mcand_q, acc_q, acc_nxt;
  logic [WIDTH-1:0]   mplier_q;
  logic               mul_sf_q, mul_start;

  assign mul_start = accept && (bus.op == OP_MUL);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  // vld_pipe walks a single token; it reaches the top on the last iteration.
  always_comb begin
    state_d = state_q;
    wr_mul  = 1'b0;
    case (state_q)
      IDLE:    if (mul_start) state_d = MUL;
      MUL:     if (vld_pipe[STAGES]) begin wr_mul = 1'b1; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
  end

  assign acc_nxt = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      vld_pipe <= '0;
      mul_sf_q <= 1'b0;
    end else if (mul_start) begin
      mcand_q  <= {{WIDTH{1'b0}}, bus.a};
      mplier_q <= bus.b;
      acc_q    <= '0;
      vld_pipe <= {{STAGES{1'b0}}, 1'b1};
      mul_sf_q <= bus.set_flags;
    end else if (state_q == MUL) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b0};
    end
  end

  always_comb begin
    mul_rsp.res  = acc_nxt[WIDTH-1:0];
    mul_rsp.nzcv = {acc_nxt[WIDTH-1], acc_nxt[WIDTH-1:0] == '0, 1'b0, |acc_nxt[2*WIDTH-1:WIDTH]};
  end

  assign idle     = (state_q == IDLE);
  assign bus.busy = (state_q == MUL);
  assign wr_alu   = accept && (bus.op != OP_MUL);
  assign mul_sf   = mul_sf_q;
`else
  // op 110 falls through the ALU default: result 0, flags 0100.
  assign idle     = 1'b1;
  assign bus.busy = 1'b0;
  assign wr_alu   = accept;
  assign wr_mul   = 1'b0;
  assign mul_sf   = 1'b0;
  assign mul_rsp  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      nzcv_q      <= '0;
      out_valid_q <= 1'b0;
    end else if (wr_alu) begin
      result_q    <= alu_rsp.res;
      if (bus.set_flags || bus.op == OP_CMP) nzcv_q <= alu_rsp.nzcv;
      out_valid_q <= 1'b1;
    end else if (wr_mul) begin
      result_q    <= mul_rsp.res;
      if (mul_sf) nzcv_q <= mul_rsp.nzcv;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_nzcv_seq.sv
// Self-checking bench for alu_nzcv_seq (WIDTH=4): directed table, handshake and
// multiplier corner cases, then randomized traffic against an arithmetic model.
module tb_alu_nzcv_seq;
  localparam int W = 4;
  localparam int M = 1 << W;
  localparam int H = M / 2;
`ifdef ALU_NZCV_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk, rst_n;
  alu_nzcv_seq_if #(.WIDTH(W)) bus ();
  alu_nzcv_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int op, input int a, input int b, input bit sf);
    bus.in_valid  = 1'b1;
    bus.op        = 3'(op);
    bus.a         = W'(a);
    bus.b         = W'(b);
    bus.set_flags = sf;
  endtask

  // Reference: {result, nzcv} from signed/unsigned integer arithmetic.
  function automatic logic [W+3:0] ref_alu(input int op, input int a, input int b, input int c);
    int r, s, sa, sb, p;
    bit cf, vf, arith;
    sa = (a >= H) ? a - M : a;
    sb = (b >= H) ? b - M : b;
    r = 0; s = 0; cf = 0; vf = 0; arith = 1;
    case (op)
      0:    begin r = (a + b) % M;                cf = (a + b) >= M;        s = sa + sb; end
      1, 7: begin r = ((a - b) % M + M) % M;      cf = a >= b;              s = sa - sb; end
      4:    begin r = (a + b + c) % M;            cf = (a + b + c) >= M;    s = sa + sb + c; end
      5:    begin r = ((a - b - 1 + c) % M + M) % M; cf = (a - b - 1 + c) >= 0; s = sa - sb - 1 + c; end
      2:    begin r = a & b; arith = 0; end
      3:    begin r = a | b; arith = 0; end
      default: begin
        arith = 0;
        if (MUL_EN) begin p = a * b; r = p % M; vf = p >= M; end
      end
    endcase
    if (arith) vf = (s < -H) || (s >= H);
    return {W'(r), (r >= H), (r == 0), cf, vf};
  endfunction

  typedef struct {
    int op; int a; int b; bit sf; int res; int nzcv;
  } vec_t;
  vec_t vecs[9];

  task automatic run_mul(input int a, input int b, input int exp_res, input int exp_nzcv);
    int cycles;
    drive(6, a, b, 1'b1);
    step();
    bus.in_valid = 1'b0;
    cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      check("mul_busy", bus.busy, 1);
      check("mul_in_ready", bus.in_ready, 0);
      step();
      cycles++;
    end
    check("mul_latency", cycles, W);
    check("mul_result", bus.result, exp_res);
    check("mul_nzcv", bus.nzcv, exp_nzcv);
    check("mul_busy_done", bus.busy, 0);
  endtask

  // random-phase model state
  int  m_res, m_nzcv, mul_left, pend_res, pend_nzcv;
  bit  m_valid, pend_sf, exp_rdy, acc;
  int  aop, aa, ab;
  bit  asf;
  logic [W+3:0] r;

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.op = '0; bus.set_flags = 1'b0;

    vecs[0] = '{0, 7, 1, 1, 4'h8, 4'b1001};
    vecs[1] = '{1, 3, 3, 1, 4'h0, 4'b0110};
    vecs[2] = '{7, 2, 5, 0, 4'hD, 4'b1000};
    vecs[3] = '{0, 15, 1, 1, 4'h0, 4'b0110};
    vecs[4] = '{4, 0, 0, 0, 4'h1, 4'b0110};
    vecs[5] = '{2, 5, 3, 1, 4'h1, 4'b0000};
    vecs[6] = '{5, 5, 2, 0, 4'h2, 4'b0000};
    vecs[7] = '{3, 8, 1, 0, 4'h9, 4'b0000};
    vecs[8] = '{1, 8, 1, 1, 4'h7, 4'b0011};

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_nzcv", bus.nzcv, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // back-to-back table, one op per cycle
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sf);
      #1 check("tbl_in_ready", bus.in_ready, 1);
      step();
      check($sformatf("tbl%0d_result", i), bus.result, vecs[i].res);
      check($sformatf("tbl%0d_nzcv", i), bus.nzcv, vecs[i].nzcv);
      check($sformatf("tbl%0d_out_valid", i), bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    step();
    check("drain_out_valid", bus.out_valid, 0);

    // back-pressure
    bus.out_ready = 1'b0;
    drive(0, 1, 1, 1'b0);
    step();
    check("hold_result", bus.result, 2);
    check("hold_out_valid", bus.out_valid, 1);
    drive(0, 3, 3, 1'b0);
    repeat (3) begin
      #1 check("hold_in_ready", bus.in_ready, 0);
      step();
      check("hold_result_stable", bus.result, 2);
      check("hold_valid_stable", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    #1 check("release_in_ready", bus.in_ready, 1);
    step();
    check("release_result", bus.result, 6);
    check("release_out_valid", bus.out_valid, 1);
    check("release_nzcv", bus.nzcv, 4'b0011);
    bus.in_valid = 1'b0;
    step();
    check("release_drain", bus.out_valid, 0);

`ifdef ALU_NZCV_SEQ_MUL_EN
    run_mul(5, 3, 4'hF, 4'b1000);
    run_mul(5, 4, 4'h4, 4'b0001);
    drive(6, 7, 7, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    check("midmul_rst_busy", bus.busy, 0);
`else
    drive(6, 5, 3, 1'b1);
    step();
    check("nomul_result", bus.result, 0);
    check("nomul_nzcv", bus.nzcv, 4'b0100);
    check("nomul_out_valid", bus.out_valid, 1);
    check("nomul_busy", bus.busy, 0);
    drive(0, 7, 1, 1'b1);
    step();
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
`endif
    check("midop_rst_out_valid", bus.out_valid, 0);
    check("midop_rst_nzcv", bus.nzcv, 0);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("post_rst_in_ready", bus.in_ready, 1);
    repeat (W + 2) begin
      check("post_rst_no_result", bus.out_valid, 0);
      step();
    end

    // randomized traffic vs. model
    m_res = 0; m_nzcv = 0; m_valid = 0; mul_left = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.op        = 3'($urandom_range(0, 7));
      bus.a         = W'($urandom_range(0, M - 1));
      bus.b         = W'($urandom_range(0, M - 1));
      bus.set_flags = 1'($urandom_range(0, 1));
      exp_rdy = (mul_left == 0) && (!m_valid || bus.out_ready);
      #1 check("rand_in_ready", bus.in_ready, exp_rdy);
      acc = bus.in_valid && exp_rdy;
      aop = int'(bus.op); aa = int'(bus.a); ab = int'(bus.b); asf = bus.set_flags;
      @(posedge clk);
      if (acc && !(MUL_EN && aop == 6)) begin
        r = ref_alu(aop, aa, ab, (m_nzcv >> 1) & 1);
        m_res = int'(r[W+3:4]);
        if (asf || aop == 7) m_nzcv = int'(r[3:0]);
        m_valid = 1;
      end else if (acc) begin
        r = ref_alu(aop, aa, ab, 0);
        pend_res = int'(r[W+3:4]); pend_nzcv = int'(r[3:0]); pend_sf = asf;
        mul_left = W;
        m_valid = 0;
      end else if (mul_left > 0) begin
        mul_left--;
        if (mul_left == 0) begin
          m_res = pend_res;
          if (pend_sf) m_nzcv = pend_nzcv;
          m_valid = 1;
        end
      end else if (m_valid && bus.out_ready) begin
        m_valid = 0;
      end
      #1;
      check("rand_out_valid", bus.out_valid, m_valid);
      check("rand_busy", bus.busy, mul_left > 0);
      check("rand_nzcv", bus.nzcv, m_nzcv);
      if (m_valid) check("rand_result", bus.result, m_res);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
